// File: rtl/pswd_writer.sv
// pswd_writer: two-pass password entry and single-cycle write to the password store
module pswd_writer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        authorise_bit,
  input  logic        change_req,
  input  logic [3:0]  in_toggle,
  input  logic        push_button,
  input  logic [3:0]  internalid,
  input  logic        logout,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  entry_phase
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ENTER1, ENTER2, WRITE, DONE, ERROR} state_t;
  state_t r_state, w_next;
  logic          r_pb_prev;
  logic [1:0]    r_nib_cnt;
  logic [15:0]   r_pw1, r_pw2;
  logic [3:0]    r_addr;
  logic [TW-1:0] r_timer;
  logic          r_wr_en, r_busy, r_done, r_error;
  logic [3:0]    r_wr_addr;
  logic [15:0]   r_wr_data;
  logic [1:0]    r_phase;
  logic          w_press, w_abort, w_entry, w_start, w_match;
  logic [15:0]   w_shift;
  assign w_press = push_button & ~r_pb_prev;
  assign w_abort = logout | ~authorise_bit;
  assign w_entry = (r_state == ENTER1) || (r_state == ENTER2);
  assign w_start = (r_state == IDLE) && change_req && authorise_bit;
  assign w_shift = {(r_state == ENTER1) ? r_pw1[11:0] : r_pw2[11:0], in_toggle};
  assign w_match = (w_shift == r_pw1) && (w_shift != 16'h0000);
  // next state: abort beats a press, a press beats the timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = change_req ? (authorise_bit ? ENTER1 : ERROR) : IDLE;
      ENTER1:  w_next = w_abort ? IDLE : w_press ? ((r_nib_cnt == 2'd3) ? ENTER2 : ENTER1) :
                        (r_timer == T_MAX) ? ERROR : ENTER1;
      ENTER2:  w_next = w_abort ? IDLE : w_press ? ((r_nib_cnt == 2'd3) ? (w_match ? WRITE : ERROR) : ENTER2) :
                        (r_timer == T_MAX) ? ERROR : ENTER2;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      ERROR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // entry datapath: edge detect, nibble capture, timer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pb_prev <= 1'b0;
      r_nib_cnt <= '0;
      r_pw1     <= '0;
      r_pw2     <= '0;
      r_addr    <= '0;
      r_timer   <= '0;
    end else begin
      r_pb_prev <= push_button;
      if (w_start) begin
        r_addr    <= internalid;
        r_nib_cnt <= '0;
        r_timer   <= '0;
        r_pw1     <= '0;
        r_pw2     <= '0;
      end else if (w_entry) begin
        if (w_abort) begin
          r_nib_cnt <= '0;
          r_timer   <= '0;
          r_pw1     <= '0;
          r_pw2     <= '0;
        end else if (w_press) begin
          r_nib_cnt <= r_nib_cnt + 2'd1;
          r_timer   <= '0;
          if (r_state == ENTER1) r_pw1 <= w_shift;
          else                   r_pw2 <= w_shift;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end
  // registered Moore outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_phase   <= '0;
    end else begin
      r_wr_en   <= w_next == WRITE;
      r_wr_addr <= (w_next == WRITE) ? r_addr : '0;
      r_wr_data <= (w_next == WRITE) ? r_pw1 : '0;
      r_busy    <= w_next != IDLE;
      r_done    <= w_next == DONE;
      r_error   <= w_next == ERROR;
      r_phase   <= (w_next == IDLE) ? 2'd0 : (w_next == ENTER1) ? 2'd1 : (w_next == ENTER2) ? 2'd2 : 2'd3;
    end
  end
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign entry_phase = r_phase;
endmodule

// File: tb/tb_pswd_writer.sv
// tb_pswd_writer: directed checks of the password programming controller
module tb_pswd_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        authorise_bit = 1'b1;
  logic        change_req = 1'b0;
  logic [3:0]  in_toggle = '0;
  logic        push_button = 1'b0;
  logic [3:0]  internalid = '0;
  logic        logout = 1'b0;
  logic        wr_en, busy, done, error;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  entry_phase;
  int vectors = 0;
  int errs = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, bad_idle = 0;
  int exp_wr = 0, exp_done = 0, exp_err = 0;
  logic [3:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  bit seen;

  pswd_writer #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .authorise_bit(authorise_bit), .change_req(change_req),
    .in_toggle(in_toggle), .push_button(push_button), .internalid(internalid), .logout(logout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .error(error), .entry_phase(entry_phase)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    if (wr_en) begin
      wr_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
    end else if (wr_addr != 0 || wr_data != 0) bad_idle++;
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press_edge(input logic [3:0] n);
    in_toggle = n;
    push_button = 1'b1;
    step();
    push_button = 1'b0;
  endtask

  task automatic press(input logic [3:0] n);
    press_edge(n);
    step();
  endtask

  task automatic start(input logic [3:0] id);
    internalid = id;
    change_req = 1'b1;
    step();
    change_req = 1'b0;
  endtask

  task automatic enter_word(input logic [15:0] w);
    press(w[15:12]); press(w[11:8]); press(w[7:4]); press(w[3:0]);
  endtask

  task automatic write_and_check(input string tag, input logic [3:0] id, input logic [15:0] w);
    start(id);
    enter_word(w);
    enter_word(w);
    step(); step();
    exp_wr++; exp_done++;
    check({tag, "_wrcnt"}, wr_cnt, exp_wr);
    check({tag, "_word"}, {last_addr, last_data}, {id, w});
    check({tag, "_idle"}, {busy, entry_phase}, 3'b000);
  endtask

  initial begin
    step(); step();
    check("reset_outs", {wr_en, wr_addr, wr_data, busy, done, error, entry_phase}, '0);
    reset = 1'b0;
    step();
    check("idle_outs", {wr_en, busy, done, error, entry_phase}, '0);

    // full write with cycle-exact latency, address latched at start
    start(4'h5);
    check("enter1_phase", {busy, entry_phase}, 3'b101);
    internalid = 4'h9;
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    check("enter2_phase", {busy, entry_phase}, 3'b110);
    press(4'hA); press(4'hB); press(4'hC);
    check("no_early_write", wr_cnt, 0);
    press_edge(4'hD);
    check("wr_strobe", {wr_en, wr_addr, wr_data, entry_phase}, {1'b1, 4'h5, 16'hABCD, 2'd3});
    step();
    check("done_pulse", {wr_en, done, wr_addr, wr_data}, {1'b0, 1'b1, 20'h0});
    step();
    check("after_done", {busy, done, entry_phase}, 4'b0000);
    exp_wr++; exp_done++;
    check("one_write", wr_cnt, exp_wr);

    // mismatched confirmation
    start(4'h5);
    enter_word(16'hABCD);
    press(4'hA); press(4'hB); press(4'hC);
    press_edge(4'hE);
    check("mismatch_err", {error, entry_phase, wr_en}, {1'b1, 2'd3, 1'b0});
    step();
    exp_err++;
    check("mismatch_idle", {busy, error, entry_phase}, 4'b0000);
    check("mismatch_nowr", wr_cnt, exp_wr);

    // held button counts once
    start(4'h3);
    in_toggle = 4'h1;
    push_button = 1'b1;
    repeat (10) step();
    push_button = 1'b0;
    step();
    check("held_phase", entry_phase, 2'd1);
    press(4'h2); press(4'h3); press(4'h4);
    enter_word(16'h1234);
    step(); step();
    exp_wr++; exp_done++;
    check("held_word", {last_addr, last_data}, {4'h3, 16'h1234});

    // reserved all-zero password
    start(4'h2);
    enter_word(16'h0000);
    enter_word(16'h0000);
    step();
    exp_err++;
    check("zero_err", {err_cnt, wr_cnt}, {exp_err, exp_wr});

    // unauthorised request
    authorise_bit = 1'b0;
    start(4'h1);
    check("unauth_err", {busy, error, entry_phase}, {1'b1, 1'b1, 2'd3});
    step();
    check("unauth_idle", {busy, error}, 2'b00);
    exp_err++;
    authorise_bit = 1'b1;

    // logout with a same-cycle press, then a clean write
    start(4'h4);
    enter_word(16'h1111);
    press(4'h2);
    in_toggle = 4'h2;
    push_button = 1'b1;
    logout = 1'b1;
    step();
    logout = 1'b0;
    push_button = 1'b0;
    check("logout_idle", {busy, error, wr_en, entry_phase}, 5'b0);
    step();
    check("logout_counts", {err_cnt, wr_cnt}, {exp_err, exp_wr});
    write_and_check("after_logout", 4'h6, 16'h5678);

    // reset during the confirmation entry, then a clean write
    start(4'h7);
    enter_word(16'h2222);
    press(4'h2); press(4'h2);
    check("pre_reset_phase", entry_phase, 2'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_mid", {busy, wr_en, error, entry_phase}, 5'b0);
    write_and_check("after_reset", 4'h8, 16'h9876);

    // timeout: no error for 18 idle cycles, then error arrives
    start(4'h1);
    press(4'h1);
    press_edge(4'h2);
    repeat (18) step();
    check("to_wait", {busy, entry_phase, error}, {1'b1, 2'd1, 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      seen = error;
    end
    check("to_error", seen, 1'b1);
    step();
    exp_err++;
    check("to_counts", {err_cnt, wr_cnt, busy}, {exp_err, exp_wr, 1'b0});

    // a press at idle cycle 18 restarts the timer
    start(4'h1);
    press(4'h1);
    press_edge(4'h2);
    repeat (17) step();
    press_edge(4'h3);
    repeat (18) step();
    check("restart_alive", {busy, entry_phase, err_cnt}, {1'b1, 2'd1, exp_err});
    press(4'h4);
    enter_word(16'h1234);
    step(); step();
    exp_wr++; exp_done++;
    check("restart_word", {last_addr, last_data, wr_cnt}, {4'h1, 16'h1234, exp_wr});

    check("done_count", done_cnt, exp_done);
    check("err_count", err_cnt, exp_err);
    check("idle_bus_zero", bad_idle, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
